// File: rtl/tmon_pkg.sv
`default_nettype none
// ---- tmon_pkg : state encoding and result codes shared by test_monitor ----
// ---- rev 1.0                                                          ----
package tmon_pkg;

  typedef enum logic [1:0] {
    RUN   = 2'd0,
    DRAIN = 2'd1,
    DONE  = 2'd2
  } tmon_state_t;

  localparam logic [31:0] TMON_CODE_TIMEOUT = 32'hFFFF_FFFF;
  localparam logic [31:0] TMON_CODE_DRAIN   = 32'hFFFF_FFFE;

endpackage
`default_nettype wire

// File: rtl/test_monitor_sat_counter.sv
`default_nettype none
// ---- sat_counter : up-counter that sticks at all-ones, clear beats increment ----
// ---- rev 1.0                                                                 ----
module sat_counter #(
  parameter int unsigned W = 8
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         inc,
  input  logic         clear,
  output logic [W-1:0] count
);

  logic [W-1:0] count_q;
  logic [W-1:0] count_d;

  always_comb begin
    count_d = count_q;
    if (clear) begin
      count_d = '0;
    end else if (inc && (count_q != {W{1'b1}})) begin
      count_d = count_q + W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count = count_q;

endmodule
`default_nettype wire

// File: rtl/test_monitor.sv
`default_nettype none
// ---- test_monitor : end-of-test monitor, drains pipeline then reports sticky result ----
// ---- rev 1.0 ; define TEST_MONITOR_FINISH_EN to print the result and call $finish   ----
module test_monitor
  import tmon_pkg::*;
#(
  parameter int unsigned NSTAGES   = 3,
  parameter int unsigned CNT_W     = 32,
  parameter int unsigned TIMEOUT   = 1000000,
  parameter int unsigned DRAIN_MAX = 16
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               stop_req,
  input  logic [31:0]        stop_code,
  input  logic [NSTAGES-1:0] stage_valid,
  input  logic [NSTAGES-1:0] stage_exc,
  input  logic               retire,
  output logic               done,
  output logic               pass,
  output logic               fail,
  output logic               timeout,
  output logic [31:0]        exit_code,
  output logic [CNT_W-1:0]   cycle_count,
  output logic [CNT_W-1:0]   retire_count
);

  localparam int unsigned   DW           = $clog2(DRAIN_MAX + 1);
  localparam logic [DW-1:0] DRAIN_LAST   = DW'(DRAIN_MAX - 1);
  localparam logic [63:0]   TIMEOUT_LAST = 64'(TIMEOUT) - 64'd1;

  tmon_state_t      state_q;
  logic             done_q, pass_q, fail_q, timeout_q;
  logic [31:0]      exit_code_q;
  logic [31:0]      hold_q;
  logic [CNT_W-1:0] cycle_cnt;
  logic [CNT_W-1:0] retire_cnt;
  logic [DW-1:0]    drain_cnt;
  logic             active, in_drain, quiet, to_hit, stop_take;

  assign active    = (state_q != DONE);
  assign in_drain  = (state_q == DRAIN);
  assign stop_take = (state_q == RUN) && stop_req;
  assign quiet     = ~|stage_valid & ~|stage_exc;
  // Compare in 64 bits so any CNT_W/TIMEOUT combination is well defined.
  assign to_hit    = (TIMEOUT != 0) && (64'(cycle_cnt) >= TIMEOUT_LAST);

  sat_counter #(.W(CNT_W)) u_cycle_cnt (
    .clk   (clk),
    .reset (reset),
    .inc   (active),
    .clear (1'b0),
    .count (cycle_cnt)
  );

  sat_counter #(.W(CNT_W)) u_retire_cnt (
    .clk   (clk),
    .reset (reset),
    .inc   (active & retire),
    .clear (1'b0),
    .count (retire_cnt)
  );

  sat_counter #(.W(DW)) u_drain_cnt (
    .clk   (clk),
    .reset (reset),
    .inc   (in_drain),
    .clear (stop_take),
    .count (drain_cnt)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= RUN;
      done_q      <= 1'b0;
      pass_q      <= 1'b0;
      fail_q      <= 1'b0;
      timeout_q   <= 1'b0;
      exit_code_q <= '0;
      hold_q      <= '0;
    end else begin
      case (state_q)
        RUN: begin
          if (stop_req) begin
            hold_q  <= stop_code;
            state_q <= DRAIN;
          end else if (to_hit) begin
            state_q     <= DONE;
            done_q      <= 1'b1;
            fail_q      <= 1'b1;
            timeout_q   <= 1'b1;
            exit_code_q <= TMON_CODE_TIMEOUT;
          end
        end
        DRAIN: begin
          if (quiet) begin
            state_q     <= DONE;
            done_q      <= 1'b1;
            pass_q      <= (hold_q == 32'd0);
            fail_q      <= (hold_q != 32'd0);
            exit_code_q <= hold_q;
          end else if (drain_cnt == DRAIN_LAST) begin
            state_q     <= DONE;
            done_q      <= 1'b1;
            fail_q      <= 1'b1;
            exit_code_q <= TMON_CODE_DRAIN;
          end else if (to_hit) begin
            state_q     <= DONE;
            done_q      <= 1'b1;
            fail_q      <= 1'b1;
            timeout_q   <= 1'b1;
            exit_code_q <= TMON_CODE_TIMEOUT;
          end
        end
        default: begin
          state_q <= DONE;
        end
      endcase
    end
  end

  assign done         = done_q;
  assign pass         = pass_q;
  assign fail         = fail_q;
  assign timeout      = timeout_q;
  assign exit_code    = exit_code_q;
  assign cycle_count  = cycle_cnt;
  assign retire_count = retire_cnt;

`ifdef TEST_MONITOR_FINISH_EN
  always_ff @(posedge clk) begin
    if (done_q) begin
      $display("test_monitor: exit_code=%h cycle_count=%0d retire_count=%0d",
               exit_code_q, cycle_cnt, retire_cnt);
      $finish;
    end
  end
`else
  // Result is reported only through the output ports in this build.
`endif

endmodule
`default_nettype wire
